vec_stream_tx: RTL and testbench



---
 rtl/vec_stream_tx_pkg.sv | 17 +
 rtl/vec_stream_tx_if.sv | 25 ++
 rtl/vec_stream_tx_mem.sv | 32 +++
 rtl/vec_stream_tx.sv | 119 +++++++++++
 tb/tb_vec_stream_tx.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_stream_tx_pkg.sv
// Shared types and helpers for the ping-pong vector transmitter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package vec_stream_tx_pkg;

    // Occupancy of one storage bank: FREE accepts a new vector, FULL is being replayed.
    typedef enum logic {
        FREE = 1'b0,
        FULL = 1'b1
    } bank_state_t;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vec_stream_tx_if.sv
// Bundles the load stream (s_*) and transmit stream (m_*) of the transmitter.
// Latency: n/a (wiring only).
// Backpressure: s_ready from the transmitter, m_ready from downstream.
//   slave  : the transmitter's view (consumes s_*, produces m_*)
//   master : the surrounding logic's view (produces s_*, consumes m_*)
interface vec_stream_tx_if #(
    parameter int T = 8
);
    logic [T-1:0] s_data_in;
    logic         s_valid;
    logic         s_ready;
    logic [T-1:0] m_data_out;
    logic         m_valid;
    logic         m_ready;

    modport slave (
        input  s_data_in, s_valid, m_ready,
        output s_ready, m_data_out, m_valid
    );

    modport master (
        output s_data_in, s_valid, m_ready,
        input  s_ready, m_data_out, m_valid
    );
endinterface

// File: rtl/vec_stream_tx_mem.sv
// Two-bank vector storage, addressed as {bank, word index}.
// Latency: write on rising edge, read is combinational.
// Backpressure: none; the caller guarantees write and read target different banks.
//   wr_en_i/wr_addr_i/wr_data_i : synchronous write port
//   rd_addr_i/rd_data_o         : asynchronous read port
module vec_stream_tx_mem
    import vec_stream_tx_pkg::*;
#(
    parameter int N = 8,
    parameter int T = 8
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [cnt_w(N):0]     wr_addr_i,
    input  logic [T-1:0]          wr_data_i,
    input  logic [cnt_w(N):0]     rd_addr_i,
    output logic [T-1:0]          rd_data_o
);
    localparam int AW = cnt_w(N) + 1;

    // Contents are deliberately not reset; bank state decides what is valid.
    logic [T-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/vec_stream_tx.sv
// Ping-pong transmitter: loads N-word vectors and replays each REPS times downstream.
// Latency: first word valid one cycle after the vector's last load handshake.
// Backpressure: s_ready drops while the write bank is FULL; output holds while m_valid && !m_ready.
//   clk, reset : clock and synchronous active-high reset
//   bus        : s_data_in/s_valid/s_ready load stream, m_data_out/m_valid/m_ready output stream
module vec_stream_tx
    import vec_stream_tx_pkg::*;
#(
    parameter int N    = 8,
    parameter int T    = 8,
    parameter int REPS = 1
) (
    input  logic           clk,
    input  logic           reset,
    vec_stream_tx_if.slave bus
);
    localparam int IW = cnt_w(N);
    localparam int PW = cnt_w(REPS);

    bank_state_t bank_st_q [2];
    bank_state_t bank_st_d [2];
    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [IW-1:0] wc_q, wc_d;
    logic [IW-1:0] rc_q, rc_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [T-1:0]  m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;

    logic          wr_en;
    logic          out_ld;
    logic [T-1:0]  rd_data;

    vec_stream_tx_mem #(
        .N (N),
        .T (T)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i ({wb_q, wc_q}),
        .wr_data_i (bus.s_data_in),
        .rd_addr_i ({rb_q, rc_q}),
        .rd_data_o (rd_data)
    );

    assign bus.s_ready    = !reset && (bank_st_q[wb_q] == FREE);
    assign bus.m_data_out = m_data_q;
    assign bus.m_valid    = m_valid_q;

    assign wr_en  = bus.s_valid && bus.s_ready;
    // Refill the output register whenever it is empty or drained this cycle.
    assign out_ld = (!m_valid_q || bus.m_ready) && (bank_st_q[rb_q] == FULL);

    always_comb begin
        bank_st_d = bank_st_q;
        wb_d      = wb_q;
        rb_d      = rb_q;
        wc_d      = wc_q;
        rc_d      = rc_q;
        pc_d      = pc_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;

        // Load side: fill bank wb, hand it over on the last word.
        if (wr_en) begin
            if (wc_q == IW'(N - 1)) begin
                wc_d            = '0;
                bank_st_d[wb_q] = FULL;
                wb_d            = ~wb_q;
            end else begin
                wc_d = wc_q + 1'b1;
            end
        end

        // Transmit side: walk bank rb REPS times, then release it.
        // Load and transmit never touch the same bank, so both updates can land together.
        if (out_ld) begin
            m_data_d  = rd_data;
            m_valid_d = 1'b1;
            if (rc_q == IW'(N - 1)) begin
                rc_d = '0;
                if (pc_q == PW'(REPS - 1)) begin
                    pc_d            = '0;
                    bank_st_d[rb_q] = FREE;
                    rb_d            = ~rb_q;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end else begin
                rc_d = rc_q + 1'b1;
            end
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_st_q <= '{FREE, FREE};
            wb_q      <= 1'b0;
            rb_q      <= 1'b0;
            wc_q      <= '0;
            rc_q      <= '0;
            pc_q      <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            bank_st_q <= bank_st_d;
            wb_q      <= wb_d;
            rb_q      <= rb_d;
            wc_q      <= wc_d;
            rc_q      <= rc_d;
            pc_q      <= pc_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end

endmodule

// File: tb/tb_vec_stream_tx.sv
// Bench for vec_stream_tx: two instances (REPS=1 and REPS=2) driven by directed and random stimulus.
// Expected output comes from a vector-level model: every completed input vector queues REPS copies.
// A monitor pops that queue on each output handshake and also checks hold-under-backpressure.
module tb_vec_stream_tx;
    localparam int N = 8;
    localparam int T = 8;
    typedef logic [T-1:0] word_t;

    logic  clk = 1'b0;
    logic  reset;
    always #5 clk = ~clk;

    word_t sd [2];
    logic  sv [2];
    logic  mr [2];
    logic  sr [2];
    logic  mv [2];
    word_t md [2];

    vec_stream_tx_if #(.T(T)) if0 ();
    vec_stream_tx_if #(.T(T)) if1 ();

    assign if0.s_data_in = sd[0];
    assign if0.s_valid   = sv[0];
    assign if0.m_ready   = mr[0];
    assign sr[0]         = if0.s_ready;
    assign mv[0]         = if0.m_valid;
    assign md[0]         = if0.m_data_out;
    assign if1.s_data_in = sd[1];
    assign if1.s_valid   = sv[1];
    assign if1.m_ready   = mr[1];
    assign sr[1]         = if1.s_ready;
    assign mv[1]         = if1.m_valid;
    assign md[1]         = if1.m_data_out;

    vec_stream_tx #(.N(N), .T(T), .REPS(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    vec_stream_tx #(.N(N), .T(T), .REPS(2)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    word_t q0 [$];
    word_t q1 [$];
    word_t part [2][N];
    int    pcnt [2];
    logic  hold_prev [2];
    word_t hold_dat [2];

    function automatic int reps_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic void q_push(input int d, input word_t w);
        if (d == 0) q0.push_back(w); else q1.push_back(w);
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic word_t q_pop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // A finished vector is owed to the output REPS times in a row.
    function automatic void push_vec(input int d);
        for (int r = 0; r < reps_of(d); r++)
            for (int i = 0; i < N; i++)
                q_push(d, part[d][i]);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    if (d == 0) q0.delete(); else q1.delete();
                    pcnt[d]      = 0;
                    hold_prev[d] = 1'b0;
                end else begin
                    if (hold_prev[d]) begin
                        chk($sformatf("hold_valid_dut%0d", d), mv[d], 1);
                        chk($sformatf("hold_data_dut%0d", d), md[d], hold_dat[d]);
                    end
                    hold_prev[d] = mv[d] && !mr[d];
                    hold_dat[d]  = md[d];
                    if (mv[d] && mr[d]) begin
                        if (q_size(d) == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL spurious_word_dut%0d: got %0h, expected no output", d, md[d]);
                        end else begin
                            chk($sformatf("data_dut%0d", d), md[d], q_pop(d));
                        end
                    end
                    if (sv[d] && sr[d]) begin
                        part[d][pcnt[d]] = sd[d];
                        pcnt[d]++;
                        if (pcnt[d] == N) begin
                            push_vec(d);
                            pcnt[d] = 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Offer one word; returns at posedge+1 just after its handshake edge.
    task automatic send(input int d, input word_t w, output int waits);
        sd[d] = w;
        sv[d] = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!sr[d] && waits < 300) begin
            waits++;
            @(negedge clk);
        end
        chk($sformatf("send_accept_dut%0d", d), sr[d], 1);
        @(posedge clk);
        #1;
        sv[d] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int w;
    int sv_b [8] = '{-5, -14, 0, -5, 13, 6, 11, -13};

    initial begin
        reset = 1'b1;
        sd[0] = '0; sd[1] = '0;
        sv[0] = 1'b0; sv[1] = 1'b0;
        mr[0] = 1'b1; mr[1] = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_s_ready0", sr[0], 0);
        chk("rst_s_ready1", sr[1], 0);
        chk("rst_m_valid0", mv[0], 0);
        chk("rst_m_valid1", mv[1], 0);
        chk("rst_m_data0", md[0], 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready0", sr[0], 1);
        chk("post_rst_s_ready1", sr[1], 1);
        @(posedge clk); #1;

        // REPS=1 back-to-back load, one-cycle latency, 8-word burst then idle
        for (int i = 0; i < N; i++) begin
            send(0, word_t'(i + 1), w);
            chk("a_no_stall", w, 0);
        end
        @(negedge clk);
        chk("a_latency_not_early", mv[0], 0);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("a_stream_valid", mv[0], 1);
            chk("a_stream_data", md[0], i + 1);
        end
        @(negedge clk);
        chk("a_idle_after", mv[0], 0);
        @(posedge clk); #1;

        // REPS=2 signed vector, 16 words without a bubble
        for (int i = 0; i < N; i++) send(1, word_t'(sv_b[i]), w);
        @(negedge clk);
        chk("b_latency_not_early", mv[1], 0);
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            chk("b_no_bubble", mv[1], 1);
            if (i == 0) chk("b_signed_first", md[1], 8'hFB);
        end
        @(negedge clk);
        chk("b_idle_after", mv[1], 0);
        @(posedge clk); #1;

        // Sparse input: nothing leaves before the vector completes
        for (int i = 0; i < N; i++) begin
            send(0, word_t'(10 * i + 3), w);
            if (i < N - 1) begin
                repeat (2) begin
                    @(negedge clk);
                    chk("e_no_partial", mv[0], 0);
                    @(posedge clk); #1;
                end
            end
        end
        repeat (12) @(negedge clk);
        chk("e_drained", q_size(0), 0);
        @(posedge clk); #1;

        // Ping-pong: both banks fill under m_ready=0, then stream A then B
        mr[0] = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            send(0, word_t'(i + 1), w);
            chk("pp_load_no_stall", w, 0);
        end
        sd[0] = word_t'(17);
        sv[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("pp_full_stall", sr[0], 0);
        end
        @(posedge clk); #1;
        sv[0] = 1'b0;
        mr[0] = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            chk("pp_no_bubble", mv[0], 1);
            chk("pp_s_ready", sr[0], (i >= N - 1) ? 1 : 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("pp_idle_after", mv[0], 0);
        @(posedge clk); #1;

        // Random data and gaps under 1,0,0,1,... then random m_ready
        begin
            logic ld_done;
            ld_done = 1'b0;
            fork
                begin
                    int wl;
                    for (int v = 0; v < 3; v++) begin
                        for (int i = 0; i < N; i++) begin
                            send(1, word_t'($urandom), wl);
                            repeat ($urandom_range(0, 2)) begin
                                @(posedge clk); #1;
                            end
                        end
                    end
                    ld_done = 1'b1;
                end
                begin
                    int k;
                    k = 0;
                    while (!(ld_done && q_size(1) == 0 && !mv[1]) && k < 3000) begin
                        mr[1] = (k < 16) ? ((k % 4 == 0) || (k % 4 == 3))
                                         : 1'($urandom_range(0, 1));
                        @(posedge clk); #1;
                        k++;
                    end
                    mr[1] = 1'b1;
                    chk("bp_drained", q_size(1), 0);
                end
            join
        end
        @(posedge clk); #1;

        // Reset with 4 words sent and 3 words of the next vector loaded
        mr[0] = 1'b0;
        for (int i = 0; i < N; i++) send(0, word_t'(101 + i), w);
        for (int i = 0; i < 3; i++) send(0, word_t'(201 + i), w);
        mr[0] = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        mr[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_s_ready", sr[0], 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_m_valid", mv[0], 0);
        chk("mid_rst_m_data", md[0], 0);
        chk("mid_rst_s_ready_after", sr[0], 1);
        mr[0] = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) send(0, word_t'(i + 1), w);
        repeat (12) @(negedge clk);
        chk("f_drained", q_size(0), 0);
        chk("f_no_stale", mv[0], 0);
        chk("final_q1_empty", q_size(1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
